// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// Occupancy state, the default bubble instruction and the beat record
// used by decode-side consumers that work at the default 32/32 widths.
package ifid_pkg;

    localparam int IFID_PC_W_DEF   = 32;
    localparam int IFID_INSN_W_DEF = 32;

    // Instruction word presented to decode after a flush (a bubble).
    localparam logic [IFID_INSN_W_DEF-1:0] IFID_NOP_INSN = 32'h0000_0000;

    // Occupancy of the stage: main register only, or main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } ifid_state_t;

    // One fetched beat as carried from fetch to decode.
    typedef struct packed {
        logic [IFID_PC_W_DEF-1:0]   pc_4;
        logic [IFID_INSN_W_DEF-1:0] instruction;
    } ifid_beat_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data holding register for the IF/ID stage.
// Priority: reset > flush > load > clear > hold.
module pipe_skid_slot #(
    parameter int           W         = 64,
    parameter logic [W-1:0] FLUSH_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Slot register: reset and flush turn it into a bubble, load captures a beat.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the data word is reset as well, because decode sees all-zero outputs after reset.
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            q     <= FLUSH_VAL;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake and flush-to-bubble.
// Build option: define IFID_SKID_EN to add a skid slot and register if_ready,
// removing the combinational id_ready -> if_ready path.
module if_id_pipe_reg
    import ifid_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(IFID_NOP_INSN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [PC_W-1:0]   if_pc_4,
    input  logic [INSN_W-1:0] if_instruction,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc_4,
    output logic [INSN_W-1:0] id_instruction
);

    localparam int                BEAT_W    = PC_W + INSN_W;
    localparam logic [BEAT_W-1:0] FLUSH_VAL = {{PC_W{1'b0}}, NOP_INSN};

    logic              main_valid;
    logic [BEAT_W-1:0] main_q;
    logic [BEAT_W-1:0] main_d;
    logic              main_load;
    logic              main_clear;
    logic [BEAT_W-1:0] if_beat;
    logic              accept;
    logic              consume;
    ifid_state_t       state;

    assign if_beat = {if_pc_4, if_instruction};

`ifdef IFID_SKID_EN
    logic              skid_valid;
    logic [BEAT_W-1:0] skid_q;
    logic              skid_load;
    logic              skid_clear;

    // Ready comes straight from the skid flop: no path from id_ready.
    assign if_ready = ~skid_valid;
    assign state    = skid_valid ? FULL : (main_valid ? BUSY : EMPTY);
`else
    // Without a skid slot the stage can only take a beat if the held one leaves.
    assign if_ready = ~main_valid | id_ready;
    assign state    = main_valid ? BUSY : EMPTY;
`endif

    assign accept  = if_valid & if_ready;
    assign consume = main_valid & id_ready;

    // Next-state control for the main (and skid) slot from occupancy and handshakes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = if_beat;
`ifdef IFID_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif
        case (state)
            EMPTY: main_load = accept;
            BUSY: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (accept) begin
`ifdef IFID_SKID_EN
                    skid_load = 1'b1;
`endif
                end else if (consume) begin
                    main_clear = 1'b1;
                end
            end
            FULL: begin
`ifdef IFID_SKID_EN
                if (consume) begin
                    main_load  = 1'b1;
                    main_d     = skid_q;
                    skid_clear = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    pipe_skid_slot #(
        .W         (BEAT_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .flush (flush),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

`ifdef IFID_SKID_EN
    pipe_skid_slot #(
        .W         (BEAT_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .flush (flush),
        .d     (if_beat),
        .valid (skid_valid),
        .q     (skid_q)
    );
`endif

    assign id_valid       = main_valid;
    assign id_pc_4        = main_q[BEAT_W-1:INSN_W];
    assign id_instruction = main_q[INSN_W-1:0];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg (either build of IFID_SKID_EN).
// Directed vectors followed by a random valid/ready/flush run against a queue model.
module tb_if_id_pipe_reg;
    import ifid_pkg::*;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc_4;
    logic [31:0] id_instruction;

    int tests_run = 0;
    int tests_failed = 0;

    ifid_beat_t model_q[$];
    ifid_beat_t head;
    logic       model_ready;

    if_id_pipe_reg #(
        .PC_W     (32),
        .INSN_W   (32),
        .NOP_INSN (TB_NOP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc_4        (if_pc_4),
        .if_instruction (if_instruction),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc_4        (id_pc_4),
        .id_instruction (id_instruction)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn);
        if_valid       = v;
        if_pc_4        = pc;
        if_instruction = insn;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        id_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Reset for two cycles.
        step();
        step();
        check("rst_valid", 64'(id_valid), 64'd0);
        check("rst_pc", 64'(id_pc_4), 64'd0);
        check("rst_insn", 64'(id_instruction), 64'd0);
        check("rst_ready", 64'(if_ready), 64'd1);

        // Stream three beats at full throughput.
        reset = 1'b0;
        id_ready = 1'b1;
        drive(1'b1, 32'd4, 32'h0000_0093);
        step();
        check("str_valid0", 64'(id_valid), 64'd1);
        check("str_pc0", 64'(id_pc_4), 64'd4);
        check("str_insn0", 64'(id_instruction), 64'h93);
        drive(1'b1, 32'd8, 32'h0000_0113);
        step();
        check("str_valid1", 64'(id_valid), 64'd1);
        check("str_pc1", 64'(id_pc_4), 64'd8);
        drive(1'b1, 32'd12, 32'h0000_0193);
        step();
        check("str_valid2", 64'(id_valid), 64'd1);
        check("str_pc2", 64'(id_pc_4), 64'd12);
        check("str_insn2", 64'(id_instruction), 64'h193);
        drive(1'b0, 32'd0, 32'd0);
        step();
        check("str_drain", 64'(id_valid), 64'd0);

        // Stall: hold 0x04 for three cycles with decode back-pressure.
        id_ready = 1'b0;
        drive(1'b1, 32'h04, 32'h8C01_0000);
        step();
        check("stl_valid", 64'(id_valid), 64'd1);
        check("stl_pc", 64'(id_pc_4), 64'h04);
        check("stl_insn", 64'(id_instruction), 64'h8C01_0000);
        drive(1'b1, 32'h08, 32'h8C02_0000);
        #1;
`ifdef IFID_SKID_EN
        check("stl_ready_skid", 64'(if_ready), 64'd1);
`else
        check("stl_ready", 64'(if_ready), 64'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            check("stl_hold_pc", 64'(id_pc_4), 64'h04);
            check("stl_hold_insn", 64'(id_instruction), 64'h8C01_0000);
            check("stl_hold_valid", 64'(id_valid), 64'd1);
            check("stl_ready_low", 64'(if_ready), 64'd0);
        end
        drive(1'b0, 32'd0, 32'd0);
        id_ready = 1'b1;
        step();
`ifdef IFID_SKID_EN
        check("rel_valid", 64'(id_valid), 64'd1);
        check("rel_pc", 64'(id_pc_4), 64'h08);
        check("rel_insn", 64'(id_instruction), 64'h8C02_0000);
        step();
`endif
        check("rel_empty", 64'(id_valid), 64'd0);

        // Flush with the stage held (FULL with skid, BUSY without).
        id_ready = 1'b0;
        drive(1'b1, 32'h10, 32'hAAAA_0001);
        step();
        drive(1'b1, 32'h14, 32'hAAAA_0002);
        step();
        drive(1'b0, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", 64'(id_valid), 64'd0);
        check("fl_insn", 64'(id_instruction), 64'(TB_NOP));
        check("fl_pc", 64'(id_pc_4), 64'd0);
        check("fl_ready", 64'(if_ready), 64'd1);
        id_ready = 1'b1;
        step();
        check("fl_nohold", 64'(id_valid), 64'd0);
        step();
        check("fl_nohold2", 64'(id_valid), 64'd0);

        // Flush in the same cycle as an accept: 0x20 is discarded, 0x24 passes.
        drive(1'b1, 32'h20, 32'hBBBB_0020);
        flush = 1'b1;
        #1;
        check("fa_ready", 64'(if_ready), 64'd1);
        step();
        flush = 1'b0;
        check("fa_drop", 64'(id_valid), 64'd0);
        drive(1'b1, 32'h24, 32'hBBBB_0024);
        step();
        check("fa_valid", 64'(id_valid), 64'd1);
        check("fa_pc", 64'(id_pc_4), 64'h24);
        check("fa_insn", 64'(id_instruction), 64'hBBBB_0024);
        drive(1'b0, 32'd0, 32'd0);
        step();

        // Reset while a beat is held under back-pressure.
        id_ready = 1'b0;
        drive(1'b1, 32'h30, 32'hCCCC_0030);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("rs_held", 64'(id_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rs_valid", 64'(id_valid), 64'd0);
        check("rs_pc", 64'(id_pc_4), 64'd0);
        check("rs_insn", 64'(id_instruction), 64'd0);
        check("rs_ready", 64'(if_ready), 64'd1);

        // Random valid/ready with occasional flush against a queue model.
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom(), $urandom());
            id_ready = 1'($urandom_range(0, 2) != 0);
            flush    = 1'($urandom_range(0, 15) == 0);
            @(negedge clock);
`ifdef IFID_SKID_EN
            model_ready = (model_q.size() < 2);
`else
            model_ready = (model_q.size() == 0) || id_ready;
`endif
            check("rnd_ready", 64'(if_ready), 64'(model_ready));
            check("rnd_valid", 64'(id_valid), 64'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                head = model_q[0];
                check("rnd_pc", 64'(id_pc_4), 64'(head.pc_4));
                check("rnd_insn", 64'(id_instruction), 64'(head.instruction));
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (model_q.size() != 0 && id_ready) void'(model_q.pop_front());
                if (if_valid && model_ready) model_q.push_back('{pc_4: if_pc_4, instruction: if_instruction});
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline register with valid/ready handshake, flush-to-bubble and optional skid buffering. It sits between instruction fetch and decode and replaces the free-running IF/ID latch so the pipeline can stall on decode back-pressure and squash fetched instructions on branch or jump redirect. Data is carried unmodified with one cycle of latency. A bubble is always presented to decode as `NOP_INSN` with `id_valid` low.

## Interface
- `PC_W`, 32, width of `pc_4` fields.
- `INSN_W`, 32, width of instruction fields.
- `NOP_INSN`, 0 (`INSN_W` bits), instruction word driven on `id_instruction` after flush.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high. Clears all state on the rising edge where it is sampled high.
- `if_valid` in 1: fetch presents a beat.
- `if_ready` out 1: stage can accept a beat this cycle.
- `if_pc_4` in `PC_W`: PC+4 of the fetched instruction.
- `if_instruction` in `INSN_W`: fetched instruction.
- `flush` in 1: squash all held and incoming beats (branch/jump redirect).
- `id_valid` out 1: decode-side beat valid.
- `id_ready` in 1: decode consumes the beat this cycle.
- `id_pc_4` out `PC_W`: registered PC+4.
- `id_instruction` out `INSN_W`: registered instruction.

## Operation
- Beat transfer rules:
  - Accept occurs when `if_valid & if_ready`.
  - Consume occurs when `id_valid & id_ready`.
  - Decode must not rely on `id_pc_4`/`id_instruction` while `id_valid` is 0.
- Data path: the main register drives `id_*`. The skid register exists only with `IFID_SKID_EN`.
- States: `EMPTY` (main invalid), `BUSY` (main valid), `FULL` (main and skid valid; skid builds only).
  - `EMPTY` + accept → `BUSY`.
  - `BUSY` + accept + consume → `BUSY`: main reloads.
  - `BUSY` + consume only → `EMPTY`.
  - `BUSY` + accept without consume → `FULL`: beat goes to skid. Skid builds only; otherwise this case cannot occur.
  - `FULL` + consume → `BUSY`: skid moves to main. `if_ready` is 0 in `FULL`, so no accept.
  - Any other combination holds state and data.
- Flush, applied on the next edge with priority over accept and consume:
  - All valids are cleared.
  - `id_instruction <= NOP_INSN`, `id_pc_4 <= 0`.
  - A beat accepted in the flush cycle is discarded.
  - `if_ready` is not gated by `flush`.
- Reset has priority over flush and behaves the same, except `id_instruction <= 0`.
  - Reset mid-stall drops both held beats.
- Outputs after reset: `id_valid=0`, `id_pc_4=0`, `id_instruction=0`, `if_ready=1`.
  - Without skid, this `if_ready` value follows from `id_valid=0`.
- Widths are pass-through only; no arithmetic is performed.

## Timing
- Latency: a beat accepted at edge N appears on `id_*` with `id_valid=1` after edge N.
- Throughput: one beat per cycle while `id_ready=1`.
- Held data is stable while `id_valid & ~id_ready`.
- Without skid: `if_ready = ~id_valid | id_ready`. This is a combinational path from `id_ready`.
- With skid: `if_ready = ~skid_valid`, taken directly from a flop. There is no combinational path from `id_ready` to `if_ready`.
- Flush asserted at edge N: `id_valid=0` after edge N. The first post-redirect beat can be accepted at edge N+1.

## Configuration
- `IFID_SKID_EN` defined: the skid register and `FULL` state are built, and `if_ready` is registered. Full throughput is kept across one stall cycle without a combinational ready chain.
- `IFID_SKID_EN` undefined: single register with combinational `if_ready`. The `FULL` state is unreachable and not built.
- Handshake semantics and flush/reset behaviour are identical in both builds.

## Structure
- Package `ifid_pkg`:
  - state enum `ifid_state_t` (`EMPTY`, `BUSY`, `FULL`);
  - default `NOP_INSN` constant;
  - typedef for the `{pc_4, instruction}` beat struct.
- Sub-module `pipe_skid_slot`: one valid+data register with load/clear/flush.
  - Instantiated once for main, and once more for skid under `IFID_SKID_EN`.

## Test plan
- Reset then stream:
  - Reset 2 cycles, then `if_valid=1`, `id_ready=1`, pc_4 = 4, 8, 12.
  - `id_valid`=1 one cycle later, and `id_pc_4` follows 4, 8, 12 with no gaps.
- Stall:
  - Beat 0x04/0x8C010000 accepted, then `id_ready=0` for 3 cycles.
  - `id_*` holds 0x04/0x8C010000.
  - Without skid: `if_ready=0` during the stall.
  - With skid: one extra beat (0x08) is absorbed and then `if_ready=0`. Release yields 0x04 then 0x08.
- Flush while `FULL` (skid build):
  - `flush=1` for one cycle.
  - Next cycle `id_valid=0`, `id_instruction=NOP_INSN`, `id_pc_4=0`, `if_ready=1`. Neither held beat is ever output.
- Flush with simultaneous accept (pc_4=0x20):
  - Beat 0x20 never appears.
  - Beat 0x24, presented the cycle after, appears one cycle later.
- Reset mid-stall, with a valid beat held and `id_ready=0`:
  - Assert `reset` for 1 cycle.
  - Next cycle all outputs are 0 and `if_ready=1`.
- Random valid/ready with occasional flush against a scoreboard:
  - No beat is lost or duplicated except those squashed by a flush.
  - Order is preserved.
